// File: rtl/abs_diff_eval_pkg.sv
// Shared types and helpers for the absolute-difference error monitor.
package abs_diff_eval_pkg;

    // Run-level state of the monitor.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } mon_state_e;

    // Error magnitude width: one bit wider than the wider of operand and
    // approximate-result widths so |approx - exact| never overflows.
    function automatic int err_width(input int w, input int ow);
        return ((w > ow) ? w : ow) + 1;
    endfunction

    // Exact |a-b| on 32-bit containers; callers zero-extend and truncate.
    function automatic logic [31:0] exact_abs_diff(input logic [31:0] a, input logic [31:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/abs_err_stage.sv
// Registered first pipeline stage: computes the exact |a-b| and the error
// magnitude of the approximate result, carrying operands and a valid bit.
module abs_err_stage
    import abs_diff_eval_pkg::*;
#(
    parameter  int W  = 6,
    parameter  int OW = 6,
    localparam int E  = err_width(W, OW)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_fire,
    input  logic [W-1:0]  in_a,
    input  logic [W-1:0]  in_b,
    input  logic [OW-1:0] in_approx,
    output logic          s1_valid,
    output logic [W-1:0]  s1_a,
    output logic [W-1:0]  s1_b,
    output logic [E-1:0]  s1_err
);

    logic          valid_q, valid_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic [E-1:0]  err_q, err_d;
    logic [W-1:0]  exact_w;
    logic [E-1:0]  exact_e;
    logic [E-1:0]  approx_e;

    // Exact difference, error magnitude and next-state of the stage registers.
    always_comb begin
        exact_w  = W'(exact_abs_diff(32'(in_a), 32'(in_b)));
        exact_e  = E'(exact_w);
        approx_e = E'(in_approx);
        valid_d  = in_fire;
        a_d      = a_q;
        b_d      = b_q;
        err_d    = err_q;
        if (in_fire) begin
            a_d   = in_a;
            b_d   = in_b;
            err_d = (approx_e >= exact_e) ? (approx_e - exact_e) : (exact_e - approx_e);
        end
    end

    // Stage registers; reset flushes the sample so nothing partial survives.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            err_q   <= '0;
        end else begin
            valid_q <= valid_d;
            a_q     <= a_d;
            b_q     <= b_d;
            err_q   <= err_d;
        end
    end

    assign s1_valid = valid_q;
    assign s1_a     = a_q;
    assign s1_b     = b_q;
    assign s1_err   = err_q;

endmodule

// File: rtl/abs_diff_err_monitor.sv
// Streaming error-metric collector: run FSM, handshake, and stage-2
// accumulators (counts, worst-case error with operands, saturating sum).
module abs_diff_err_monitor
    import abs_diff_eval_pkg::*;
#(
    parameter  int W     = 6,
    parameter  int OW    = 6,
    parameter  int CNT_W = 16,
    parameter  int SUM_W = 24,
    localparam int E     = err_width(W, OW)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] n_samples,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_a,
    input  logic [W-1:0]     in_b,
    input  logic [OW-1:0]    in_approx,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] sample_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [E-1:0]     max_err,
    output logic [W-1:0]     wce_a,
    output logic [W-1:0]     wce_b,
    output logic [SUM_W-1:0] sum_err
);

    // Wide enough to hold sum + err without wrapping before the saturation test.
    localparam int               SW      = ((SUM_W > E) ? SUM_W : E) + 1;
    localparam logic [SUM_W-1:0] SUM_MAX = '1;

    mon_state_e       state_q, state_d;
    logic [CNT_W-1:0] n_q, n_d;
    logic [CNT_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] sample_cnt_q, sample_cnt_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [E-1:0]     max_err_q, max_err_d;
    logic [W-1:0]     wce_a_q, wce_a_d;
    logic [W-1:0]     wce_b_q, wce_b_d;
    logic [SUM_W-1:0] sum_err_q, sum_err_d;
    logic             s2_valid_q, s2_valid_d;

    logic             fire;
    logic             start_ok;
    logic             s1_valid;
    logic [W-1:0]     s1_a;
    logic [W-1:0]     s1_b;
    logic [E-1:0]     s1_err;
    logic [SW-1:0]    sum_wide;

    // in_ready depends only on registered state, never on in_valid.
    assign in_ready = (state_q == RUN) && (acc_q < n_q);
    assign fire     = in_valid && in_ready;
    assign start_ok = start && ((state_q == IDLE) || (state_q == DONE));
    assign busy     = (state_q == RUN) || (state_q == DRAIN);
    assign done     = (state_q == DONE);

    abs_err_stage #(
        .W  (W),
        .OW (OW)
    ) u_stage1 (
        .clk       (clk),
        .rst       (rst),
        .in_fire   (fire),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_approx (in_approx),
        .s1_valid  (s1_valid),
        .s1_a      (s1_a),
        .s1_b      (s1_b),
        .s1_err    (s1_err)
    );

    // Run FSM: launch, count accepted samples, drain both stages, hold results.
    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        acc_d   = acc_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    n_d     = n_samples;
                    acc_d   = '0;
                    state_d = (n_samples == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (fire) begin
                    acc_d = acc_q + CNT_W'(1);
                    if ((acc_q + CNT_W'(1)) == n_q) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (!s1_valid && !s2_valid_q) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Stage-2 accumulators; a new run clears them before any sample arrives.
    always_comb begin
        sample_cnt_d = sample_cnt_q;
        err_cnt_d    = err_cnt_q;
        max_err_d    = max_err_q;
        wce_a_d      = wce_a_q;
        wce_b_d      = wce_b_q;
        sum_err_d    = sum_err_q;
        s2_valid_d   = s1_valid;
        sum_wide     = SW'(sum_err_q) + SW'(s1_err);
        if (start_ok) begin
            sample_cnt_d = '0;
            err_cnt_d    = '0;
            max_err_d    = '0;
            wce_a_d      = '0;
            wce_b_d      = '0;
            sum_err_d    = '0;
            s2_valid_d   = 1'b0;
        end else if (s1_valid) begin
            sample_cnt_d = sample_cnt_q + CNT_W'(1);
            if (s1_err != '0) begin
                err_cnt_d = err_cnt_q + CNT_W'(1);
            end
            sum_err_d = (sum_wide > SW'(SUM_MAX)) ? SUM_MAX : SUM_W'(sum_wide);
            // Strictly greater: on a tie the earlier sample's operands stay.
            if (s1_err > max_err_q) begin
                max_err_d = s1_err;
                wce_a_d   = s1_a;
                wce_b_d   = s1_b;
            end
        end
    end

    // State and metric registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            n_q          <= '0;
            acc_q        <= '0;
            sample_cnt_q <= '0;
            err_cnt_q    <= '0;
            max_err_q    <= '0;
            wce_a_q      <= '0;
            wce_b_q      <= '0;
            sum_err_q    <= '0;
            s2_valid_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            n_q          <= n_d;
            acc_q        <= acc_d;
            sample_cnt_q <= sample_cnt_d;
            err_cnt_q    <= err_cnt_d;
            max_err_q    <= max_err_d;
            wce_a_q      <= wce_a_d;
            wce_b_q      <= wce_b_d;
            sum_err_q    <= sum_err_d;
            s2_valid_q   <= s2_valid_d;
        end
    end

    assign sample_cnt = sample_cnt_q;
    assign err_cnt    = err_cnt_q;
    assign max_err    = max_err_q;
    assign wce_a      = wce_a_q;
    assign wce_b      = wce_b_q;
    assign sum_err    = sum_err_q;

endmodule

// File: tb/tb_abs_diff_err_monitor.sv
// Directed bench for abs_diff_err_monitor: table-driven runs plus hand-written
// sequences for backpressure, empty runs, reset mid-run and saturation.
module tb_abs_diff_err_monitor;

    localparam int W     = 6;
    localparam int OW    = 6;
    localparam int CNT_W = 16;
    localparam int SUM_W = 24;
    localparam int E     = 7;
    localparam int NR    = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [CNT_W-1:0] n_samples;
    logic             in_valid;
    logic [W-1:0]     in_a;
    logic [W-1:0]     in_b;
    logic [OW-1:0]    in_approx;

    logic             in_ready, busy, done;
    logic [CNT_W-1:0] sample_cnt, err_cnt;
    logic [E-1:0]     max_err;
    logic [W-1:0]     wce_a, wce_b;
    logic [SUM_W-1:0] sum_err;

    logic             s_in_ready, s_busy, s_done;
    logic [CNT_W-1:0] s_sample_cnt, s_err_cnt;
    logic [E-1:0]     s_max_err;
    logic [W-1:0]     s_wce_a, s_wce_b;
    logic [3:0]       s_sum_err;

    abs_diff_err_monitor #(.W(W), .OW(OW), .CNT_W(CNT_W), .SUM_W(SUM_W)) u_dut (
        .clk(clk), .rst(rst), .start(start), .n_samples(n_samples),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .in_approx(in_approx), .busy(busy), .done(done), .sample_cnt(sample_cnt),
        .err_cnt(err_cnt), .max_err(max_err), .wce_a(wce_a), .wce_b(wce_b),
        .sum_err(sum_err)
    );

    // Narrow-sum instance sharing the same stimulus, for the saturation case.
    abs_diff_err_monitor #(.W(W), .OW(OW), .CNT_W(CNT_W), .SUM_W(4)) u_sat (
        .clk(clk), .rst(rst), .start(start), .n_samples(n_samples),
        .in_valid(in_valid), .in_ready(s_in_ready), .in_a(in_a), .in_b(in_b),
        .in_approx(in_approx), .busy(s_busy), .done(s_done), .sample_cnt(s_sample_cnt),
        .err_cnt(s_err_cnt), .max_err(s_max_err), .wce_a(s_wce_a), .wce_b(s_wce_b),
        .sum_err(s_sum_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int n;
        int e_cnt;
        int e_max;
        int e_wa;
        int e_wb;
        int e_sum;
        int e_sum_sat;
    } run_t;

    run_t runs[NR];
    int   sa[NR][4];
    int   sb[NR][4];
    int   sap[NR][4];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic do_start(input int n);
        start     = 1'b1;
        n_samples = CNT_W'(n);
        @(negedge clk);
        start     = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!done && lat < 50) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic set_run(input int r, input int n, input int ec, input int em,
                           input int wa, input int wb, input int es, input int ess);
        runs[r].n = n; runs[r].e_cnt = ec; runs[r].e_max = em;
        runs[r].e_wa = wa; runs[r].e_wb = wb; runs[r].e_sum = es; runs[r].e_sum_sat = ess;
    endtask

    task automatic set_smp(input int r, input int i, input int a, input int b, input int ap);
        sa[r][i] = a; sb[r][i] = b; sap[r][i] = ap;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int k;
        int cyc;

        // Run table: samples and hand-computed metrics (sum for SUM_W=24 and SUM_W=4).
        set_run(0, 4, 0, 0, 0, 0, 0, 0);
        set_smp(0, 0, 40, 12, 28); set_smp(0, 1, 12, 40, 28);
        set_smp(0, 2, 0, 0, 0);    set_smp(0, 3, 63, 0, 63);
        set_run(1, 3, 3, 3, 5, 9, 8, 8);
        set_smp(1, 0, 40, 12, 30); set_smp(1, 1, 5, 9, 1);
        set_smp(1, 2, 20, 20, 3);  set_smp(1, 3, 0, 0, 0);
        set_run(2, 3, 3, 7, 10, 0, 21, 15);
        set_smp(2, 0, 10, 0, 3);   set_smp(2, 1, 10, 0, 3);
        set_smp(2, 2, 10, 0, 3);   set_smp(2, 3, 0, 0, 0);
        set_run(3, 2, 2, 63, 0, 63, 126, 15);
        set_smp(3, 0, 0, 63, 0);   set_smp(3, 1, 63, 63, 63);
        set_smp(3, 2, 0, 0, 0);    set_smp(3, 3, 0, 0, 0);

        rst = 1'b1; start = 1'b0; n_samples = '0; in_valid = 1'b0;
        in_a = '0; in_b = '0; in_approx = '0;
        repeat (3) @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_ready", in_ready, 0);
        chk("reset_sample_cnt", sample_cnt, 0);
        chk("reset_sum_err", sum_err, 0);
        rst = 1'b0;
        @(negedge clk);
        $display("reset: busy=%0d done=%0d sample_cnt=%0d", busy, done, sample_cnt);

        for (int r = 0; r < NR; r++) begin
            do_start(runs[r].n);
            chk("run_busy", busy, 1);
            for (int i = 0; i < runs[r].n; i++) begin
                in_valid  = 1'b1;
                in_a      = W'(sa[r][i]);
                in_b      = W'(sb[r][i]);
                in_approx = OW'(sap[r][i]);
                chk("run_ready", in_ready, 1);
                @(negedge clk);
            end
            in_valid = 1'b0;
            wait_done(lat);
            chk("run_done_latency", lat, 3);
            chk("run_busy_at_done", busy, 0);
            chk("run_sample_cnt", sample_cnt, runs[r].n);
            chk("run_err_cnt", err_cnt, runs[r].e_cnt);
            chk("run_max_err", max_err, runs[r].e_max);
            chk("run_wce_a", wce_a, runs[r].e_wa);
            chk("run_wce_b", wce_b, runs[r].e_wb);
            chk("run_sum_err", sum_err, runs[r].e_sum);
            chk("run_sum_err_sat", s_sum_err, runs[r].e_sum_sat);
            $display("run %0d: n=%0d lat=%0d err_cnt=%0d max_err=%0d wce=(%0d,%0d) sum=%0d sat_sum=%0d",
                     r, runs[r].n, lat, err_cnt, max_err, wce_a, wce_b, sum_err, s_sum_err);
        end

        // Backpressure: valid alternates; ready must drop after the 5th transfer.
        do_start(5);
        k = 0;
        cyc = 0;
        while (k < 5 && cyc < 40) begin
            in_valid  = ((cyc % 2) == 0);
            in_a      = W'(k + 1);
            in_b      = '0;
            in_approx = OW'(k + 1);
            if (in_valid && in_ready) k++;
            @(negedge clk);
            cyc++;
        end
        chk("bp_transfers", k, 5);
        in_valid = 1'b1;
        in_a = W'(33); in_b = '0; in_approx = OW'(1);
        chk("bp_ready_after_n", in_ready, 0);
        @(negedge clk);
        in_valid = 1'b0;
        wait_done(lat);
        chk("bp_done", done, 1);
        chk("bp_sample_cnt", sample_cnt, 5);
        chk("bp_err_cnt", err_cnt, 0);
        $display("backpressure: transfers=%0d cycles=%0d sample_cnt=%0d", k, cyc, sample_cnt);

        // Empty run: done the next cycle, previous metrics cleared, never busy.
        do_start(0);
        chk("n0_done", done, 1);
        chk("n0_busy", busy, 0);
        chk("n0_sample_cnt", sample_cnt, 0);
        chk("n0_err_cnt", err_cnt, 0);
        chk("n0_sum_err", sum_err, 0);
        chk("n0_ready", in_ready, 0);
        $display("empty run: done=%0d busy=%0d sample_cnt=%0d", done, busy, sample_cnt);

        // Reset mid-run after 2 of 6 transfers, with an ignored start during RUN.
        do_start(6);
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; in_a = W'(10); in_b = '0; in_approx = OW'(3);
            @(negedge clk);
        end
        in_valid  = 1'b0;
        start     = 1'b1;
        n_samples = CNT_W'(1);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("midrun_busy", busy, 1);
        chk("midrun_sample_cnt", sample_cnt, 2);
        chk("midrun_sum_err", sum_err, 14);
        chk("midrun_ready", in_ready, 1);
        rst       = 1'b1;
        start     = 1'b1;
        n_samples = '0;
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ready", in_ready, 0);
        chk("rst_sample_cnt", sample_cnt, 0);
        chk("rst_err_cnt", err_cnt, 0);
        chk("rst_max_err", max_err, 0);
        chk("rst_wce_a", wce_a, 0);
        chk("rst_sum_err", sum_err, 0);
        @(negedge clk);
        chk("rst_start_lost_done", done, 0);
        chk("rst_start_lost_busy", busy, 0);
        $display("reset mid-run: busy=%0d done=%0d sample_cnt=%0d", busy, done, sample_cnt);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
